// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester indices and default bus widths.
package mem_arbiter_pkg;

    localparam int unsigned AW_DEFAULT = 13;
    localparam int unsigned DW_DEFAULT = 8;

    // Requester indices; also the bit positions within gnt/done.
    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DBG = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin winner select. A lone requester always wins; on
// contention the requester that was not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dbg_req,
    input  logic       last,      // index of the last granted requester
    output logic [1:0] win        // one-hot winner, bit order as gnt
);

    // Combinational winner selection from the request pair and history.
    always_comb begin
        win = '0;
        if (cpu_req && dbg_req) begin
            if (last == 1'(REQ_DBG)) begin
                win[REQ_CPU] = 1'b1;
            end else begin
                win[REQ_DBG] = 1'b1;
            end
        end else begin
            win[REQ_CPU] = cpu_req;
            win[REQ_DBG] = dbg_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU controller and a debug loader onto one single-port
// memory. Each access runs IDLE -> ACCESS -> (WAIT x WAIT_STATES) -> RESP,
// with every output registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW          = AW_DEFAULT,
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    state_t     state;
    logic [2:0] wcnt;
    logic       last;
    logic       lat_we;
    logic [1:0] win;

    rr_arb2 u_rr (
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .last    (last),
        .win     (win)
    );

    // Access sequencer. mem_addr/mem_wdata double as the latched request,
    // so they are loaded on grant and hold until the next grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            wcnt      <= '0;
            last      <= 1'(REQ_DBG);
            lat_we    <= 1'b0;
        end else begin
            done   <= '0;
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|win) begin
                        gnt   <= win;
                        busy  <= 1'b1;
                        state <= ST_ACCESS;
                        if (win[REQ_DBG]) begin
                            lat_we    <= dbg_we;
                            mem_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end else begin
                            lat_we    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (WAIT_STATES == 0) begin
                        if (!lat_we) begin
                            rdata <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        wcnt  <= 3'(WAIT_STATES - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wcnt == 3'd0) begin
                        if (!lat_we) begin
                            rdata <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    done  <= gnt;
                    gnt   <= '0;
                    last  <= gnt[REQ_DBG];
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
